// File: rtl/sequencer_pkg.sv
// Shared opcodes, instruction field slices and FSM state type for the instruction sequencer.
// SEQUENCER_SINGLE_STEP_EN adds the StPause state.
package sequencer_pkg;

  localparam logic [3:0] OP_BRD  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int unsigned InstrWidth = 16;
  localparam int unsigned OpcodeMsb  = 15;
  localparam int unsigned OpcodeLsb  = 12;
  localparam int unsigned TargetMsb  = 11;
  localparam int unsigned TargetLsb  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StHalted
`ifdef SEQUENCER_SINGLE_STEP_EN
    , StPause
`endif
  } seq_state_e;

  function automatic logic [3:0] get_opcode(input logic [InstrWidth-1:0] instr);
    return instr[OpcodeMsb:OpcodeLsb];
  endfunction

  function automatic logic [TargetMsb-TargetLsb:0] get_target(input logic [InstrWidth-1:0] instr);
    return instr[TargetMsb:TargetLsb];
  endfunction

endpackage

// File: rtl/return_stack.sv
// Return address stack: owns the stack pointer, writes on push, reads stack[sp-1] combinationally.
// Contents are never reset; only the pointer is.
module return_stack #(
  parameter int unsigned PC_WIDTH = 12,
  parameter int unsigned SP_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [SP_WIDTH-1:0] sp,
  output logic [PC_WIDTH-1:0] top
);

  localparam int unsigned Depth = 2 ** SP_WIDTH;

  logic [PC_WIDTH-1:0] mem_q [Depth];
  logic [SP_WIDTH-1:0] sp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q <= '0;
    end else if (clear) begin
      sp_q <= '0;
    end else if (push) begin
      sp_q <= sp_q + SP_WIDTH'(1);
    end else if (pop) begin
      sp_q <= sp_q - SP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[sp_q] <= push_data;
    end
  end

  assign sp  = sp_q;
  assign top = mem_q[sp_q - SP_WIDTH'(1)];

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/issue sequencer broadcasting one instruction every three cycles to the cell array.
// SEQUENCER_SINGLE_STEP_EN adds a step input that gates each instruction through StPause.
module instruction_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 12,
  parameter int unsigned         SP_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [InstrWidth-1:0] imem_data,
  output logic [InstrWidth-1:0] instruction,
  output logic [PC_WIDTH-1:0]   next_program_counter,
  output logic [SP_WIDTH-1:0]   next_stack_pointer,
  output logic                  execution_enable,
  input  logic                  diverge_consensus,
`ifdef SEQUENCER_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  busy,
  output logic                  halted,
  output logic                  fault
);

  localparam logic [SP_WIDTH-1:0] SpMax = '1;

  seq_state_e state_q, state_d;

  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc, next_pc_q, dec_next_pc, dec_target, stack_top;
  logic [SP_WIDTH-1:0]   sp, next_sp_q, dec_next_sp;
  logic [InstrWidth-1:0] instr_q;
  logic [3:0]            dec_op, iss_op;
  logic                  fault_q, start_ok, stack_fault, push, pop, in_issue;

  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign dec_op     = get_opcode(imem_data);
  assign dec_target = PC_WIDTH'(get_target(imem_data));
  assign iss_op     = get_opcode(instr_q);
  assign in_issue   = (state_q == StIssue);
  assign start_ok   = start && ((state_q == StIdle) || (state_q == StHalted));

  assign stack_fault = ((iss_op == OP_CALL) && (sp == SpMax)) ||
                       ((iss_op == OP_RET) && (sp == '0));
  assign push = in_issue && (iss_op == OP_CALL) && !stack_fault;
  assign pop  = in_issue && (iss_op == OP_RET) && !stack_fault;
  // BRD broadcasts the target but only takes it when every cell agrees to diverge.
  assign pc_d = ((iss_op == OP_BRD) && !diverge_consensus) ? pc_inc : next_pc_q;

  return_stack #(
    .PC_WIDTH(PC_WIDTH),
    .SP_WIDTH(SP_WIDTH)
  ) u_return_stack (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .sp       (sp),
    .top      (stack_top)
  );

  // Faulting CALL/RET leave sp unchanged so the broadcast pointer never wraps.
  always_comb begin
    dec_next_pc = pc_inc;
    dec_next_sp = sp;
    case (dec_op)
      OP_BRD, OP_JMP: dec_next_pc = dec_target;
      OP_CALL: begin
        dec_next_pc = dec_target;
        if (sp != SpMax) dec_next_sp = sp + SP_WIDTH'(1);
      end
      OP_RET: begin
        if (sp != '0) begin
          dec_next_pc = stack_top;
          dec_next_sp = sp - SP_WIDTH'(1);
        end else begin
          dec_next_pc = pc_q;
        end
      end
      OP_HALT: dec_next_pc = pc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = StIssue;
      StIssue: begin
        if (stack_fault || (iss_op == OP_HALT)) begin
          state_d = StHalted;
        end else begin
`ifdef SEQUENCER_SINGLE_STEP_EN
          state_d = StPause;
`else
          state_d = StFetch;
`endif
        end
      end
`ifdef SEQUENCER_SINGLE_STEP_EN
      StPause:  if (step) state_d = StFetch;
`endif
      StHalted: if (start) state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy             = 1'b0;
    halted           = 1'b0;
    execution_enable = 1'b0;
    case (state_q)
      StFetch, StDecode: busy = 1'b1;
      StIssue: begin
        busy             = 1'b1;
        execution_enable = !stack_fault;
      end
`ifdef SEQUENCER_SINGLE_STEP_EN
      StPause:  busy = 1'b1;
`endif
      StHalted: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      next_pc_q <= '0;
      next_sp_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        pc_q    <= RESET_PC;
        fault_q <= 1'b0;
      end
      if (state_q == StDecode) begin
        instr_q   <= imem_data;
        next_pc_q <= dec_next_pc;
        next_sp_q <= dec_next_sp;
      end
      if (in_issue) begin
        if (stack_fault) begin
          fault_q <= 1'b1;
        end else begin
          pc_q <= pc_d;
        end
      end
    end
  end

  assign imem_addr            = pc_q;
  assign instruction          = instr_q;
  assign next_program_counter = next_pc_q;
  assign next_stack_pointer   = next_sp_q;
  assign fault                = fault_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: directed programs push expected broadcasts,
// a negedge monitor pops and compares on every execution_enable.
module tb_instruction_sequencer;

  localparam int unsigned PcW = 12;
  localparam int unsigned SpW = 5;
`ifdef SEQUENCER_SINGLE_STEP_EN
  localparam int Gap = 4;
`else
  localparam int Gap = 3;
`endif

  typedef struct {
    logic [15:0]    instr;
    logic [PcW-1:0] npc;
    logic [SpW-1:0] nsp;
    logic [PcW-1:0] pc_after;
    int             gap;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           diverge_consensus = 1'b0;
  logic [PcW-1:0] imem_addr;
  logic [15:0]    imem_data = '0;
  logic [15:0]    instruction;
  logic [PcW-1:0] next_program_counter;
  logic [SpW-1:0] next_stack_pointer;
  logic           execution_enable, busy, halted, fault;

  logic [15:0] imem [4096];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_en = 0;
  bit          addr_pending = 0;
  logic [PcW-1:0] pend_addr;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= imem[imem_addr];

  instruction_sequencer #(
    .PC_WIDTH(PcW),
    .SP_WIDTH(SpW),
    .RESET_PC('0)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .imem_addr           (imem_addr),
    .imem_data           (imem_data),
    .instruction         (instruction),
    .next_program_counter(next_program_counter),
    .next_stack_pointer  (next_stack_pointer),
    .execution_enable    (execution_enable),
    .diverge_consensus   (diverge_consensus),
`ifdef SEQUENCER_SINGLE_STEP_EN
    .step                (1'b1),
`endif
    .busy                (busy),
    .halted              (halted),
    .fault               (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares each broadcast and the fetch address that follows it.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (addr_pending) begin
      addr_pending = 0;
      check("fetch_addr", 32'(imem_addr), 32'(pend_addr));
    end
    if (execution_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_enable: got instr 0x%0h, expected no enable", instruction);
      end else begin
        e = exp_q.pop_front();
        check("instruction", 32'(instruction), 32'(e.instr));
        check("next_pc", 32'(next_program_counter), 32'(e.npc));
        check("next_sp", 32'(next_stack_pointer), 32'(e.nsp));
        if (e.gap != 0) check("enable_gap", 32'(cyc - last_en), 32'(e.gap));
        pend_addr    = e.pc_after;
        addr_pending = 1;
      end
      last_en = cyc;
    end
  end

  task automatic expect_op(input logic [15:0] instr, input int npc, input int nsp,
                           input int pc_after, input int gap);
    exp_t e;
    e.instr = instr; e.npc = PcW'(npc); e.nsp = SpW'(nsp);
    e.pc_after = PcW'(pc_after); e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = 16'hF000;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL %s_halt_timeout: got halted=0, expected halted=1", name);
    end
  endtask

  task automatic drain(input string name);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_enables: got %0d outstanding, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    clear_imem();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_enable", 32'(execution_enable), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    check("rst_instruction", 32'(instruction), 0);
    check("rst_next_pc", 32'(next_program_counter), 0);
    check("rst_next_sp", 32'(next_stack_pointer), 0);
    rst = 1'b1;

    // Straight line, with a start pulse while busy that must be ignored.
    imem[0] = 16'h1000; imem[1] = 16'h2000; imem[2] = 16'hF000;
    expect_op(16'h1000, 1, 0, 1, 0);
    expect_op(16'h2000, 2, 0, 2, Gap);
    expect_op(16'hF000, 2, 0, 2, Gap);
    pulse_start();
    repeat (1) @(negedge clk);
    pulse_start();
    wait_halted("straight");
    check("straight_fault", 32'(fault), 0);
    drain("straight");

    // JMP
    clear_imem();
    imem[0] = 16'hC005;
    expect_op(16'hC005, 5, 0, 5, 0);
    expect_op(16'hF000, 5, 0, 5, Gap);
    pulse_start();
    wait_halted("jmp");
    drain("jmp");

    // CALL/RET
    clear_imem();
    imem[0] = 16'hD010; imem[16'h10] = 16'hE000;
    expect_op(16'hD010, 16'h10, 1, 16'h10, 0);
    expect_op(16'hE000, 1, 0, 1, Gap);
    expect_op(16'hF000, 1, 0, 1, Gap);
    pulse_start();
    wait_halted("callret");
    drain("callret");

    // BRD taken and not taken
    clear_imem();
    imem[0] = 16'hB020;
    diverge_consensus = 1'b1;
    expect_op(16'hB020, 16'h20, 0, 16'h20, 0);
    expect_op(16'hF000, 16'h20, 0, 16'h20, Gap);
    pulse_start();
    wait_halted("brd_taken");
    drain("brd_taken");
    diverge_consensus = 1'b0;
    expect_op(16'hB020, 16'h20, 0, 1, 0);
    expect_op(16'hF000, 1, 0, 1, Gap);
    pulse_start();
    wait_halted("brd_not_taken");
    drain("brd_not_taken");

    // RET underflow
    clear_imem();
    imem[0] = 16'hE000;
    pulse_start();
    wait_halted("underflow");
    check("underflow_fault", 32'(fault), 1);
    check("underflow_next_sp", 32'(next_stack_pointer), 0);
    check("underflow_instr", 32'(instruction), 32'h0000E000);
    drain("underflow");

    // 32 nested CALLs: the 32nd overflows
    clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 16'hD000 | 16'(i + 1);
    for (int i = 0; i < 31; i++) expect_op(16'hD000 | 16'(i + 1), i + 1, i + 1, i + 1, 0);
    pulse_start();
    check("restart_clears_fault", 32'(fault), 0);
    wait_halted("overflow");
    check("overflow_fault", 32'(fault), 1);
    check("overflow_next_sp", 32'(next_stack_pointer), 31);
    check("overflow_instr", 32'(instruction), 32'h0000D020);
    drain("overflow");

    // Reset during DECODE of the second instruction
    clear_imem();
    imem[0] = 16'h1000; imem[1] = 16'h1000;
    expect_op(16'h1000, 1, 0, 1, 0);
    pulse_start();
    check("start_clears_fault", 32'(fault), 0);
    check("start_busy", 32'(busy), 1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_enable", 32'(execution_enable), 0);
    check("abort_imem_addr", 32'(imem_addr), 0);
    check("abort_instruction", 32'(instruction), 0);
    check("abort_next_pc", 32'(next_program_counter), 0);
    drain("abort");
    rst = 1'b1;
    expect_op(16'h1000, 1, 0, 1, 0);
    expect_op(16'h1000, 2, 0, 2, Gap);
    expect_op(16'hF000, 2, 0, 2, Gap);
    pulse_start();
    wait_halted("after_reset");
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
